// File: rtl/dense2_argmax.sv
// Argmax over ten signed 16-bit class scores from the dense2 stage.
// One lane is scanned per enabled cycle; results are registered on the DONE cycle.
module dense2_argmax (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         valid_in,
  input  logic [159:0] dense_sum2_in,
  output logic         busy,
  output logic         done,
  output logic [3:0]   digit,
  output logic [15:0]  max_value,
  output logic         overrun,
  output logic [15:0]  frame_cnt
);

  // state | meaning
  // IDLE  | waiting for valid_in
  // SCAN  | comparing lanes 1..9 against the running max
  // DONE  | publishing result; may capture the next frame
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [9:0][15:0]   buf_q, buf_d;
  logic [3:0]         idx_q, idx_d;
  logic [15:0]        run_max_q, run_max_d;
  logic [3:0]         arg_q, arg_d;
  logic               done_q, done_d;
  logic [3:0]         digit_q, digit_d;
  logic [15:0]        max_value_q, max_value_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [15:0]        lane;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      run_max_q   <= '0;
      arg_q       <= '0;
      done_q      <= 1'b0;
      digit_q     <= '0;
      max_value_q <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      run_max_q   <= run_max_d;
      arg_q       <= arg_d;
      done_q      <= done_d;
      digit_q     <= digit_d;
      max_value_q <= max_value_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    run_max_d   = run_max_q;
    arg_d       = arg_q;
    done_d      = 1'b0;
    digit_d     = digit_q;
    max_value_d = max_value_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    lane        = buf_q[idx_q];

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            buf_d     = dense_sum2_in;
            run_max_d = dense_sum2_in[15:0];
            arg_d     = 4'd0;
            idx_d     = 4'd1;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          // A new frame arriving mid-scan is dropped, not queued.
          if (valid_in) overrun_d = 1'b1;
          if ($signed(lane) > $signed(run_max_q)) begin
            run_max_d = lane;
            arg_d     = idx_q;
          end
          if (idx_q == 4'd9) begin
            idx_d   = 4'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        DONE: begin
          digit_d     = arg_q;
          max_value_d = run_max_q;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (valid_in) begin
            buf_d     = dense_sum2_in;
            run_max_d = dense_sum2_in[15:0];
            arg_d     = 4'd0;
            idx_d     = 4'd1;
            state_d   = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign digit     = digit_q;
  assign max_value = max_value_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/dense2_argmax.md
DENSE2_ARGMAX -- requirements
Module: dense2_argmax

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named per the codebase convention.
REQ-002 clk  in  1  rising-edge clock; sole clock domain.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ena  in  1  global enable; when 0, all state holds.
REQ-005 valid_in  in  1  single-cycle strobe marking dense_sum2_in as valid; driven by the upstream dense2 stage's valid.
REQ-006 dense_sum2_in  in  160  ten signed 16-bit class scores; lane k occupies bits [16k+15:16k].
REQ-007 busy  out  1  high whenever the state is not IDLE; decoded from the state register.
REQ-008 done  out  1  registered; one-cycle pulse when digit and max_value update.
REQ-009 digit  out  4  registered; index 0..9 of the maximum score.
REQ-010 max_value  out  16  registered; signed maximum score.
REQ-011 overrun  out  1  registered, sticky; a frame was dropped.
REQ-012 frame_cnt  out  16  registered; count of completed classifications.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-014 In every state, an edge with ena=0 SHALL freeze state, the buffer, the index, the running max and all outputs, except that done SHALL be cleared.
REQ-015 Capture: IDLE or DONE with ena=1 and valid_in=1 SHALL:
- latch all 160 bits into the internal buffer;
- load the running max with lane 0 and the running argmax with 0;
- load idx with 1;
- go to SCAN.
REQ-016 In SCAN with ena=1, each edge SHALL compare buffer lane idx against the running max, signed two's complement.
REQ-017 The running max and argmax SHALL be replaced only when lane idx is strictly greater, so the lowest index wins ties.
REQ-018 In SCAN, idx SHALL increment by 1 per enabled edge; the edge that processes idx=9 SHALL move the FSM to DONE.
REQ-019 In DONE with ena=1, the FSM SHALL:
- load digit and max_value from the running argmax and max;
- set done=1 for that cycle only;
- increment frame_cnt modulo 2^16, wrapping 0xFFFF to 0x0000;
- go to SCAN if valid_in=1 (capture per REQ-015), else to IDLE.
REQ-020 Latency with ena continuously 1: done SHALL be high in the cycle following the 10th rising edge after the edge that captures valid_in.
REQ-021 Sustained throughput SHALL be one frame per 10 cycles.
REQ-022 valid_in=1 in SCAN with ena=1 SHALL be ignored: buffer untouched and no restart.
REQ-023 The REQ-022 case SHALL set overrun to 1, which holds until reset.
REQ-024 valid_in while ena=0 SHALL be ignored and SHALL NOT set overrun.
REQ-025 digit and max_value SHALL hold their last values between done pulses.
REQ-026 No arithmetic is performed; comparisons SHALL be full 16-bit signed with no saturation.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL enter IDLE regardless of ena or the current state, including mid-SCAN with no done for the aborted frame.
REQ-028 Reset values: busy=0, done=0, digit=0, max_value=0x0000, overrun=0, frame_cnt=0, idx=0, running max=0, argmax=0, buffer=0.
REQ-029 The first edge after rst deasserts SHALL be able to capture valid_in.

Verification
REQ-030 Lanes 9..0 = FD41,FF89,FD84,00C4,01CC,0446,0116,FD11,0012,00A8 with one valid_in pulse -> done 10 cycles later; digit=4, max_value=0x0446, frame_cnt=1.
REQ-031 Tie and negatives:
- all lanes 0x0100 -> digit=0, max_value=0x0100;
- all lanes 0xFF00 except lane 9=0xFFFF -> digit=9, max_value=0xFFFF.
REQ-032 Overrun: valid_in at cycle 0 and at cycle 3 -> exactly one done, at cycle 10, with frame-0 data; overrun=1 and stays 1.
REQ-033 Back-to-back: second valid_in coincident with the DONE cycle -> second done 10 cycles after the first; overrun=0; frame_cnt=2.
REQ-034 Stall: ena=0 for 4 cycles mid-SCAN -> done delayed to cycle 14 with the correct digit; valid_in during the stall is ignored and overrun stays 0.
REQ-035 Reset mid-SCAN at idx=5 -> next cycle busy=0, digit=0, frame_cnt=0; no done pulse; a following frame classifies correctly.
